cordic_channel_scheduler: RTL
=============================

Name: cordic_channel_scheduler

Overview:
Round-robin scheduler that shares one serial CORDIC cos/sin engine among NCH phase requesters, e.g. per-channel tone generators in the audio codec path. It accepts angle requests, issues them one at a time to the engine, and returns each result tagged with its channel index. A watchdog flags an engine that never reports ready.

Parameters:
NCH, 4, number of requesting channels (2..16); CH_WDT = $clog2(NCH) is derived.
PHI_WDT, 18, angle width and cos/sin result width; must match the engine.
TIMEOUT, 63, maximum enabled cycles to wait in WAIT for cor_rdy before abort (≥ engine latency).

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
sclr  in  1  synchronous clear, same effect as reset
en  in  1  clock enable for all state
req  in  NCH  per-channel request; held high until matching ack
phi  in  NCH*PHI_WDT  per-channel angle; channel k occupies bits [k*PHI_WDT +: PHI_WDT]; stable while req[k] is high
ack  out  NCH  one-cycle grant/consume pulse
cor_st  out  1  start pulse to the engine
cor_phi  out  PHI_WDT  angle to the engine (registered)
cor_rdy  in  1  engine result-ready pulse
cor_cos  in  PHI_WDT  engine cosine (signed)
cor_sin  in  PHI_WDT  engine sine (signed)
out_vld  out  1  one-cycle result-valid pulse
out_ch  out  CH_WDT  channel index of the result
out_cos  out  PHI_WDT  registered signed cosine
out_sin  out  PHI_WDT  registered signed sine
busy  out  1  high when state != IDLE
err_timeout  out  1  sticky watchdog flag

Behaviour:
- All registers update only when en=1; en=0 freezes state, counters and outputs, and held pulses stay asserted.
- reset (asynchronous) or sclr (synchronous, taking priority over en) zeroes: ack, cor_st, cor_phi, out_vld, out_ch, out_cos, out_sin, busy, err_timeout, round-robin pointer ptr=0 and wait counter. State goes to IDLE.
- FSM has two states, IDLE and WAIT.
- IDLE, with any req bit high:
  - Grant g is the first requesting index scanning ptr, ptr+1, … mod NCH.
  - On that clock edge: cor_phi <= phi[g], cor_st <= 1, ack[g] <= 1 (both for exactly one cycle), ch_reg <= g, ptr <= (g+1) mod NCH, counter cleared, state -> WAIT.
- IDLE, with no request: cor_st=0 and ack=0.
- Requests and acks:
  - ack consumes the request.
  - If req[g] is still high in the cycle after ack, that is a new request and is arbitrated normally.
- WAIT:
  - Counter increments each enabled cycle.
  - If cor_rdy=1: out_cos/out_sin <= cor_cos/cor_sin, out_ch <= ch_reg, out_vld <= 1 for one cycle, state -> IDLE.
  - If the counter reaches TIMEOUT with no cor_rdy: err_timeout <= 1 (sticky until reset/sclr), no out_vld, state -> IDLE.
  - cor_rdy and timeout in the same cycle: result wins and err_timeout is not set.
- cor_rdy while in IDLE is ignored; this drops a late result after reset or timeout.
- Back-to-back timing:
  - The grant decision is made in the IDLE cycle coincident with out_vld.
  - The minimum period between cor_st pulses is engine latency + 2 cycles.
  - With a serial engine of N=13 (cor_rdy 15 cycles after cor_st), that period is 17 cycles.
- Reset mid-WAIT aborts the operation: no out_vld, and the in-flight result is dropped.
- Result width is unchanged; no arithmetic is performed on cos/sin.

Test Plan:
Test configuration: NCH=4, PHI_WDT=18, TIMEOUT=63, serial engine N=13.
1. Single request, req=0100, phi[2]=0 -> ack=0100 and cor_st in the same cycle, cor_phi=0. out_vld 16 cycles later with out_ch=2, out_cos ≈ +131071 (±4 LSB), out_sin ≈ 0 (±4 LSB).
2. Single request, phi[1]=2^16 (pi/2) -> out_ch=1, out_cos ≈ 0, out_sin ≈ +131071 (±4 LSB).
3. req=1111 held continuously from reset -> grant order 0,1,2,3,0,…, cor_st spacing 17 cycles, each out_ch matching its grant order.
4. Fairness: req[1] held high continuously, req[3] raised while channel 1 is in WAIT -> next grant is 3, then 1.
5. Engine model holding cor_rdy=0 -> after 63 enabled WAIT cycles, err_timeout=1, busy=0, no out_vld. A later req on channel 0 is served normally and err_timeout stays 1.
6. Async reset pulsed 5 cycles after cor_st -> all outputs 0 immediately; the engine's later cor_rdy produces no out_vld.
7. en toggled 1/0 every cycle during scenario 3 -> identical results and order, with all latencies doubled.

Source files
------------

// File: rtl/cordic_channel_scheduler.sv
// Round-robin scheduler sharing one serial CORDIC cos/sin engine among NCH angle
// requesters; each result is returned tagged with the channel that asked for it.
module cordic_channel_scheduler #(
    parameter  int NCH     = 4,
    parameter  int PHI_WDT = 18,
    parameter  int TIMEOUT = 63,
    localparam int CH_WDT  = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sclr,
    input  logic                   en,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*PHI_WDT-1:0] phi,
    output logic [NCH-1:0]         ack,
    output logic                   cor_st,
    output logic [PHI_WDT-1:0]     cor_phi,
    input  logic                   cor_rdy,
    input  logic [PHI_WDT-1:0]     cor_cos,
    input  logic [PHI_WDT-1:0]     cor_sin,
    output logic                   out_vld,
    output logic [CH_WDT-1:0]      out_ch,
    output logic [PHI_WDT-1:0]     out_cos,
    output logic [PHI_WDT-1:0]     out_sin,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int CNT_WDT = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WDT-1:0] CNT_LAST = CNT_WDT'(TIMEOUT - 1);
    localparam logic [CH_WDT-1:0]  CH_LAST  = CH_WDT'(NCH - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [NCH-1:0][PHI_WDT-1:0] phi_arr;
    assign phi_arr = phi;

    state_t               state_q, state_d;
    logic [CH_WDT-1:0]    ptr_q, ptr_d;
    logic [CH_WDT-1:0]    ch_q, ch_d;
    logic [CNT_WDT-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0]       ack_q, ack_d;
    logic                 cor_st_q, cor_st_d;
    logic [PHI_WDT-1:0]   cor_phi_q, cor_phi_d;
    logic                 out_vld_q, out_vld_d;
    logic [CH_WDT-1:0]    out_ch_q, out_ch_d;
    logic [PHI_WDT-1:0]   out_cos_q, out_cos_d;
    logic [PHI_WDT-1:0]   out_sin_q, out_sin_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 gnt_vld;
    logic [CH_WDT-1:0]    gnt_idx;
    logic [CH_WDT-1:0]    cand;

    // Scan from the highest offset down so the nearest requester after ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = CH_WDT'((int'(ptr_q) + i) % NCH);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        cor_st_d  = 1'b0;
        cor_phi_d = cor_phi_q;
        out_vld_d = 1'b0;
        out_ch_d  = out_ch_q;
        out_cos_d = out_cos_q;
        out_sin_d = out_sin_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    ack_d[gnt_idx] = 1'b1;
                    cor_st_d       = 1'b1;
                    cor_phi_d      = phi_arr[gnt_idx];
                    ch_d           = gnt_idx;
                    ptr_d          = (gnt_idx == CH_LAST) ? '0 : gnt_idx + 1'b1;
                    cnt_d          = '0;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the last allowed cycle still counts as good.
                if (cor_rdy) begin
                    out_vld_d = 1'b1;
                    out_ch_d  = ch_q;
                    out_cos_d = cor_cos;
                    out_sin_d = cor_sin;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ch_q      <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            cor_st_q  <= 1'b0;
            cor_phi_q <= '0;
            out_vld_q <= 1'b0;
            out_ch_q  <= '0;
            out_cos_q <= '0;
            out_sin_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (sclr) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ch_q      <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            cor_st_q  <= 1'b0;
            cor_phi_q <= '0;
            out_vld_q <= 1'b0;
            out_ch_q  <= '0;
            out_cos_q <= '0;
            out_sin_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            cor_st_q  <= cor_st_d;
            cor_phi_q <= cor_phi_d;
            out_vld_q <= out_vld_d;
            out_ch_q  <= out_ch_d;
            out_cos_q <= out_cos_d;
            out_sin_q <= out_sin_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign ack         = ack_q;
    assign cor_st      = cor_st_q;
    assign cor_phi     = cor_phi_q;
    assign out_vld     = out_vld_q;
    assign out_ch      = out_ch_q;
    assign out_cos     = out_cos_q;
    assign out_sin     = out_sin_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule
